// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and round-robin helper for the stream arbiter
package stream_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int RR_MAX_IN    = 32;
  localparam int RR_MAX_IDX_W = 5;

  // Linear-search form of the round-robin pick; returns {valid, idx}.
  function automatic logic [RR_MAX_IDX_W:0] rr_next(
    input logic [RR_MAX_IDX_W-1:0] ptr,
    input logic [RR_MAX_IN-1:0]    req,
    input int unsigned             num_in
  );
    logic                    found;
    logic [RR_MAX_IDX_W-1:0] idx;
    int unsigned             k;
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < RR_MAX_IN; j++) begin
      if (j < num_in && !found) begin
        k = (32'(ptr) + j) % num_in;
        if (req[k]) begin
          found = 1'b1;
          idx   = RR_MAX_IDX_W'(k);
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick using a double-width masked priority encoder
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              gnt_vld_o,
  output logic [IDX_W-1:0]  gnt_idx_o
);

  localparam logic [IDX_W:0] NUM_IN_W = (IDX_W+1)'(NUM_IN);

  logic [2*NUM_IN-1:0] req2;
  logic [2*NUM_IN-1:0] masked;
  logic                found;
  logic [IDX_W:0]      pos;

  // Lower copy masked below ptr, upper copy unmasked: first set bit wraps naturally.
  always_comb begin
    req2 = {req_i, req_i};
    for (int i = 0; i < 2*NUM_IN; i++) begin
      masked[i] = req2[i] & (i >= int'(ptr_i));
    end
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < 2*NUM_IN; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        pos   = (IDX_W+1)'(i);
      end
    end
    gnt_vld_o = |req_i;
    gnt_idx_o = IDX_W'((pos >= NUM_IN_W) ? (pos - NUM_IN_W) : pos);
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-granular round-robin stream arbiter with registered output slice
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int DATA_W = 8,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_IN-1:0]        en_i,
  input  logic [NUM_IN*DATA_W-1:0] data_i,
  input  logic [NUM_IN-1:0]        last_i,
  input  logic [NUM_IN-1:0]        vld_i,
  output logic [NUM_IN-1:0]        rdy_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     last_o,
  output logic [IDX_W-1:0]         src_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  output logic                     busy_o
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic              busy_q;

  logic [NUM_IN-1:0] cand;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic              slot_free;
  logic              acc;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_IN-1)) ? '0 : x + 1'b1;
  endfunction

  assign cand = vld_i & en_i;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i     (cand),
    .ptr_i     (ptr_q),
    .gnt_vld_o (pick_vld),
    .gnt_idx_o (pick_idx)
  );

  always_comb begin
    slot_free   = ~vld_q | rdy_i;
    grant_valid = pick_vld;
    grant_idx   = pick_idx;
    if (state_q == ARB_LOCKED) begin
      grant_valid = 1'b1;
      grant_idx   = owner_q;
    end

    rdy_o = '0;
    if (grant_valid && slot_free && !rst_i) begin
      rdy_o[grant_idx] = 1'b1;
    end
    acc      = grant_valid & slot_free & ~rst_i & vld_i[grant_idx];
    acc_last = last_i[grant_idx];
    acc_data = data_i[int'(grant_idx)*DATA_W +: DATA_W];

    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (acc) begin
      if (acc_last) begin
        state_d = ARB_IDLE;
        ptr_d   = idx_inc(grant_idx);
      end else if (state_q == ARB_IDLE) begin
        state_d = ARB_LOCKED;
        owner_d = grant_idx;
      end
    end

    // Output slice: load on accept, otherwise empty once downstream takes the beat.
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    src_d  = src_q;
    if (acc) begin
      vld_d  = 1'b1;
      data_d = acc_data;
      last_d = acc_last;
      src_d  = grant_idx;
    end else if (rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      src_q   <= src_d;
      busy_q  <= (state_d == ARB_LOCKED);
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign last_o = last_q;
  assign src_o  = src_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - randomized bench for stream_rr_arbiter against a behavioural model
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   en_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   last_i;
  logic [N-1:0]   vld_i;
  logic [N-1:0]   rdy_o;
  logic [W-1:0]   data_o;
  logic           last_o;
  logic [1:0]     src_o;
  logic           vld_o;
  logic           rdy_i;
  logic           busy_o;

  always #5 clk_i = ~clk_i;

  stream_rr_arbiter #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .data_i (data_i),
    .last_i (last_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .data_o (data_o),
    .last_o (last_o),
    .src_o  (src_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i),
    .busy_o (busy_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t src_q [N][$];
  beat_t out_q [N][$];
  int    obs[$];
  int    seq [N];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Model: owner < 0 means no packet in progress.
  int         m_owner = -1;
  int         m_ptr   = 0;
  bit         m_vld   = 1'b0;
  logic [7:0] m_data  = '0;
  bit         m_last  = 1'b0;
  int         m_src   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load_pkt(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {s[1:0], seq[s][5:0]};
      b.l = (i == len - 1);
      seq[s]++;
      src_q[s].push_back(b);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < N; k++) n += src_q[k].size() + out_q[k].size();
    return n;
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] en, input logic [3:0] vm, input logic rdy);
    int         g;
    int         s;
    bit         sf;
    bit         acc;
    logic [3:0] er;
    beat_t      b;
    @(negedge clk_i);
    rst_i = rst;
    en_i  = en;
    rdy_i = rdy;
    for (int k = 0; k < N; k++) begin
      if (vm[k] && src_q[k].size() > 0) begin
        vld_i[k]          = 1'b1;
        data_i[k*W +: W]  = src_q[k][0].d;
        last_i[k]         = src_q[k][0].l;
      end else begin
        vld_i[k]          = 1'b0;
        data_i[k*W +: W]  = 8'($urandom);
        last_i[k]         = 1'($urandom);
      end
    end
    #1;
    g  = -1;
    sf = !m_vld || rdy;
    if (m_owner >= 0) g = m_owner;
    else begin
      for (int j = 0; j < N; j++) begin
        if (g < 0 && vld_i[(m_ptr + j) % N] && en[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      end
    end
    er = (!rst && sf && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("rdy_o", rdy_o, er);
    acc = (er != 0) && vld_i[g];
    if (!rst && vld_o && rdy) begin
      s = int'(src_o);
      obs.push_back(s);
      chk("sb_avail", out_q[s].size() > 0, 1);
      if (out_q[s].size() > 0) begin
        b = out_q[s].pop_front();
        chk("sb_data", data_o, b.d);
        chk("sb_last", last_o, b.l);
      end
    end
    @(posedge clk_i);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_vld = 0; m_data = '0; m_last = 0; m_src = 0;
      for (int k = 0; k < N; k++) out_q[k].delete();
    end else if (acc) begin
      b = src_q[g].pop_front();
      out_q[g].push_back(b);
      m_vld = 1; m_data = b.d; m_last = b.l; m_src = g;
      if (b.l) begin
        m_owner = -1;
        m_ptr   = (g + 1) % N;
      end else begin
        m_owner = g;
      end
    end else if (rdy) begin
      m_vld = 0;
    end
    #1;
    chk("vld_o", vld_o, m_vld);
    chk("busy_o", busy_o, m_owner >= 0);
    if (m_vld || rst) begin
      chk("data_o", data_o, m_data);
      chk("last_o", last_o, m_last);
      chk("src_o", src_o, m_src);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (pending() > 0 && n < 300) begin
      cycle(1'b0, 4'hf, 4'hf, 1'b1);
      n++;
    end
    repeat (3) cycle(1'b0, 4'hf, 4'h0, 1'b1);
    chk("drain", pending(), 0);
  endtask

  task automatic chk_seq(input string tag, input int exp[8], input int cnt);
    chk({tag, "_cnt"}, obs.size() >= cnt, 1);
    for (int i = 0; i < cnt; i++) begin
      if (i < obs.size()) chk(tag, obs[i], exp[i]);
    end
  endtask

  initial begin
    logic [7:0] hold_d;
    logic [1:0] hold_s;
    logic [3:0] ren;
    rst_i = 1'b1; en_i = '0; data_i = '0; last_i = '0; vld_i = '0; rdy_i = 1'b0;
    for (int k = 0; k < N; k++) seq[k] = 0;

    // Reset with everything valid, then round-robin single beats.
    for (int k = 0; k < N; k++) repeat (3) load_pkt(k, 1);
    repeat (2) cycle(1'b1, 4'hf, 4'hf, 1'b1);
    obs.delete();
    repeat (12) cycle(1'b0, 4'hf, 4'hf, 1'b1);
    chk_seq("rr_seq", '{0, 1, 2, 3, 0, 1, 2, 3}, 8);
    drain();

    // Packet lock with a bubble while req 0 waits.
    obs.delete();
    load_pkt(2, 3);
    load_pkt(0, 1);
    cycle(1'b0, 4'hf, 4'b0100, 1'b1);
    cycle(1'b0, 4'hf, 4'b0001, 1'b1);
    cycle(1'b0, 4'hf, 4'b0101, 1'b1);
    cycle(1'b0, 4'hf, 4'b0101, 1'b1);
    repeat (4) cycle(1'b0, 4'hf, 4'b0001, 1'b1);
    chk_seq("lock_seq", '{2, 2, 2, 0, 0, 0, 0, 0}, 4);
    drain();

    // Backpressure while a beat is held.
    for (int i = 0; i < 3; i++) begin
      load_pkt(1, 1);
      load_pkt(3, 1);
    end
    cycle(1'b0, 4'hf, 4'hf, 1'b1);
    hold_d = data_o;
    hold_s = src_o;
    repeat (5) begin
      cycle(1'b0, 4'hf, 4'hf, 1'b0);
      chk("bp_data", data_o, hold_d);
      chk("bp_src", src_o, hold_s);
    end
    drain();

    // Mask and wrap: park ptr at 3, then only 0 and 3 enabled.
    load_pkt(2, 1);
    cycle(1'b0, 4'hf, 4'b0100, 1'b1);
    cycle(1'b0, 4'hf, 4'b0000, 1'b1);
    obs.delete();
    repeat (2) begin
      load_pkt(0, 1);
      load_pkt(3, 1);
    end
    load_pkt(1, 1);
    load_pkt(2, 1);
    repeat (4) cycle(1'b0, 4'b1001, 4'hf, 1'b1);
    load_pkt(3, 3);
    load_pkt(0, 1);
    cycle(1'b0, 4'b1001, 4'hf, 1'b1);
    repeat (5) cycle(1'b0, 4'b0001, 4'hf, 1'b1);
    chk_seq("mask_seq", '{3, 0, 3, 0, 3, 3, 3, 0}, 8);
    drain();

    // Reset in the middle of a locked 4-beat packet.
    load_pkt(1, 4);
    load_pkt(2, 1);
    load_pkt(3, 1);
    cycle(1'b0, 4'hf, 4'b0010, 1'b1);
    cycle(1'b0, 4'hf, 4'b0010, 1'b1);
    cycle(1'b1, 4'hf, 4'b1110, 1'b1);
    chk("mid_rst_vld", vld_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    obs.delete();
    repeat (3) cycle(1'b0, 4'hf, 4'b1110, 1'b1);
    chk("mid_rst_cnt", obs.size() >= 1, 1);
    if (obs.size() >= 1) chk("mid_rst_first", obs[0], 1);
    drain();

    // Randomized traffic, enables and backpressure.
    ren = 4'hf;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() < 3) load_pkt(k, $urandom_range(1, 4));
      end
      if (c % 16 == 0) ren = 4'($urandom);
      cycle(1'b0, ren, 4'($urandom), ($urandom % 4) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
